// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
package mult_sched_pkg;

    localparam int WIDTH_DEF      = 8;
    localparam int NREQ_DEF       = 4;
    localparam int TIMEOUT_MARGIN = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer and
// returns the pointer value that follows that winner.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [PTR_W-1:0] o_next_ptr
);

    always_comb begin
        logic             w_found;
        logic [PTR_W:0]   w_sum;
        logic [PTR_W-1:0] w_idx;
        // NOTE: every output gets a default before the loop, so no path can leave it unassigned and infer a latch.
        o_gnt      = '0;
        o_next_ptr = i_ptr;
        w_found    = 1'b0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NREQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NREQ);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_next_ptr   = (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one iterative multiplier among NREQ requesters: grant, issue, wait
// for completion (with timeout) and return the product to the winner.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [2*WIDTH-1:0]      res,
    output logic                    res_err,
    output logic                    busy,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_out,
    input  logic                    mul_ready
);

    localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TIMEOUT = WIDTH + TIMEOUT_MARGIN;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [NREQ-1:0]    r_win;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_res;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic [NREQ-1:0]    w_gnt;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req      (req),
        .i_ptr      (r_ptr),
        .o_gnt      (w_gnt),
        .o_next_ptr (w_next_ptr)
    );

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_a = a_in[i*WIDTH +: WIDTH];
                w_b = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: non-blocking assignments throughout, so every register sees the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: operand and result registers are reset as well, because they drive outputs that must read 0 in reset.
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_win   <= w_gnt;
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_ptr   <= w_next_ptr;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // mul_ready is only looked at here, so a level left high by the previous product is never reused.
                    if (mul_ready) begin
                        r_res   <= mul_out;
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_res   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = (r_state == S_ISSUE) ? r_win : '0;
    assign done      = (r_state == S_DONE)  ? r_win : '0;
    assign mul_start = (r_state == S_ISSUE);
    assign busy      = (r_state != S_IDLE);
    assign mul_a     = r_a;
    assign mul_b     = r_b;
    assign res       = r_res;
    assign res_err   = r_err;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler with a WIDTH-cycle iterative multiplier model.
module tb_mult_scheduler;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*WIDTH-1:0] a_in  = '0;
    logic [NREQ*WIDTH-1:0] b_in  = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [2*WIDTH-1:0]    res;
    logic                  res_err;
    logic                  busy;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_out;
    logic                  mul_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Multiplier model: ready drops after start, product appears WIDTH edges later, ready then stays high.
    logic               m_hang  = 1'b0;
    int                 m_cnt   = 0;
    logic [WIDTH-1:0]   m_a     = '0;
    logic [WIDTH-1:0]   m_b     = '0;
    logic               m_ready = 1'b1;
    logic [2*WIDTH-1:0] m_out   = '0;

    assign mul_ready = m_ready;
    assign mul_out   = m_out;

    mult_scheduler #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .done      (done),
        .res       (res),
        .res_err   (res_err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_out   (mul_out),
        .mul_ready (mul_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mul_start) begin
            m_ready <= 1'b0;
            m_cnt   <= WIDTH;
            m_a     <= mul_a;
            m_b     <= mul_b;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_cnt <= 0;
            if (!m_hang) begin
                m_ready <= 1'b1;
                m_out   <= (2*WIDTH)'(m_a) * (2*WIDTH)'(m_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_ops(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_in[idx*WIDTH +: WIDTH] = a;
        b_in[idx*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_gnt(input int limit, output logic [NREQ-1:0] g, output int at,
                            output logic ms, output logic [WIDTH-1:0] ma, output logic [WIDTH-1:0] mb);
        bit hit = 1'b0;
        g = '0; at = -1; ms = 1'b0; ma = '0; mb = '0;
        for (int k = 0; k < limit && !hit; k++) begin
            @(negedge clk);
            if (gnt != '0) begin
                hit = 1'b1; g = gnt; at = cyc; ms = mul_start; ma = mul_a; mb = mul_b;
            end
        end
    endtask

    task automatic wait_done(input int limit, output logic [NREQ-1:0] d, output int at,
                             output logic [2*WIDTH-1:0] r, output logic e);
        bit hit = 1'b0;
        d = '0; at = -1; r = '1; e = 1'bx;
        for (int k = 0; k < limit && !hit; k++) begin
            @(negedge clk);
            if (done != '0) begin
                hit = 1'b1; d = done; at = cyc; r = res; e = res_err;
            end
        end
    endtask

    task automatic run_op(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int dlimit, output logic [NREQ-1:0] g, output logic [NREQ-1:0] d,
                          output int lat, output logic [2*WIDTH-1:0] r, output logic e);
        int g_at, d_at;
        logic ms;
        logic [WIDTH-1:0] ma, mb;
        set_ops(idx, a, b);
        req = NREQ'(1 << idx);
        wait_gnt(20, g, g_at, ms, ma, mb);
        req = '0;
        wait_done(dlimit, d, d_at, r, e);
        lat = (g_at < 0 || d_at < 0) ? -1 : d_at - g_at;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        checks++; if (gnt !== '0 || done !== '0) begin errors++; $display("FAIL reset_pulses: gnt=%b done=%b want 0", gnt, done); end
        checks++; if (busy !== 1'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b mul_start=%b want 0", busy, mul_start); end
        checks++; if (res !== '0 || res_err !== 1'b0) begin errors++; $display("FAIL reset_res: res=%0d res_err=%b want 0", res, res_err); end
        checks++; if (mul_a !== '0 || mul_b !== '0) begin errors++; $display("FAIL reset_ops: mul_a=%0d mul_b=%0d want 0", mul_a, mul_b); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req: busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [2*WIDTH-1:0] exp_p [4] = '{16'd12, 16'd30, 16'd56, 16'd90};
        int exp_i [5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] g, d, exp_g;
        logic [2*WIDTH-1:0] r;
        logic e, ms;
        logic [WIDTH-1:0] ma, mb;
        int g_at, d_at;
        int prev = -1;
        set_ops(0, 8'd3, 8'd4);
        set_ops(1, 8'd5, 8'd6);
        set_ops(2, 8'd7, 8'd8);
        set_ops(3, 8'd9, 8'd10);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_gnt(20, g, g_at, ms, ma, mb);
            if (n == 4) req = '0;
            exp_g = NREQ'(1 << exp_i[n]);
            checks++; if (g !== exp_g) begin errors++; $display("FAIL b2b_gnt%0d: got %b want %b", n, g, exp_g); end
            if (prev >= 0) begin
                checks++; if ((g_at - prev) !== 12) begin errors++; $display("FAIL b2b_spacing%0d: got %0d want 12", n, g_at - prev); end
            end
            prev = g_at;
            wait_done(20, d, d_at, r, e);
            checks++; if (d !== exp_g) begin errors++; $display("FAIL b2b_done%0d: got %b want %b", n, d, exp_g); end
            checks++; if (r !== exp_p[exp_i[n]]) begin errors++; $display("FAIL b2b_res%0d: got %0d want %0d", n, r, exp_p[exp_i[n]]); end
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g, d;
        logic [2*WIDTH-1:0] r;
        logic e, ms;
        logic [WIDTH-1:0] ma, mb;
        int g_at, d_at;
        set_ops(0, 8'd13, 8'd11);
        req = 4'b0001;
        wait_gnt(20, g, g_at, ms, ma, mb);
        req = '0;
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", g); end
        checks++; if (ms !== 1'b1 || ma !== 8'd13 || mb !== 8'd11) begin errors++; $display("FAIL single_issue: start=%b a=%0d b=%0d want 1 13 11", ms, ma, mb); end
        @(negedge clk);
        checks++; if (gnt !== '0 || busy !== 1'b1) begin errors++; $display("FAIL single_gnt_len: gnt=%b busy=%b want 0000 1", gnt, busy); end
        set_ops(0, 8'd255, 8'd255);
        req = 4'b0000;
        wait_done(20, d, d_at, r, e);
        checks++; if (d !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", d); end
        checks++; if ((d_at - g_at) !== 10) begin errors++; $display("FAIL single_latency: got %0d want 10", d_at - g_at); end
        checks++; if (r !== 16'd143 || e !== 1'b0) begin errors++; $display("FAIL single_res: res=%0d err=%b want 143 0", r, e); end
        @(negedge clk);
        checks++; if (done !== '0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: done=%b busy=%b want 0000 0", done, busy); end
    endtask

    task automatic test_max_operands();
        logic [NREQ-1:0] g, d;
        logic [2*WIDTH-1:0] r;
        logic e;
        int lat;
        run_op(2, 8'd255, 8'd255, 20, g, d, lat, r, e);
        checks++; if (d !== 4'b0100 || r !== 16'd65025 || e !== 1'b0) begin errors++; $display("FAIL max_res: done=%b res=%0d err=%b want 0100 65025 0", d, r, e); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL max_latency: got %0d want 10", lat); end
        run_op(2, 8'd0, 8'd200, 20, g, d, lat, r, e);
        checks++; if (d !== 4'b0100 || r !== 16'd0 || e !== 1'b0) begin errors++; $display("FAIL zero_res: done=%b res=%0d err=%b want 0100 0 0", d, r, e); end
    endtask

    task automatic test_wrap();
        logic [2*WIDTH-1:0] exp_p [3] = '{16'd255, 16'd144, 16'd255};
        logic [NREQ-1:0] exp_g [3] = '{4'b1000, 4'b0001, 4'b1000};
        logic [NREQ-1:0] g, d;
        logic [2*WIDTH-1:0] r;
        logic e, ms;
        logic [WIDTH-1:0] ma, mb;
        int g_at, d_at, lat;
        run_op(2, 8'd2, 8'd2, 20, g, d, lat, r, e);
        checks++; if (r !== 16'd4) begin errors++; $display("FAIL wrap_setup: got %0d want 4", r); end
        set_ops(0, 8'd12, 8'd12);
        set_ops(3, 8'd15, 8'd17);
        req = 4'b1001;
        for (int n = 0; n < 3; n++) begin
            wait_gnt(20, g, g_at, ms, ma, mb);
            if (n == 2) req = '0;
            checks++; if (g !== exp_g[n]) begin errors++; $display("FAIL wrap_gnt%0d: got %b want %b", n, g, exp_g[n]); end
            wait_done(20, d, d_at, r, e);
            checks++; if (r !== exp_p[n]) begin errors++; $display("FAIL wrap_res%0d: got %0d want %0d", n, r, exp_p[n]); end
        end
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] g, d;
        logic [2*WIDTH-1:0] r;
        logic e;
        int lat;
        m_hang = 1'b1;
        run_op(1, 8'd6, 8'd7, 30, g, d, lat, r, e);
        checks++; if (d !== 4'b0010) begin errors++; $display("FAIL timeout_done: got %b want 0010", d); end
        checks++; if (lat !== 13) begin errors++; $display("FAIL timeout_latency: got %0d want 13", lat); end
        checks++; if (r !== 16'd0 || e !== 1'b1) begin errors++; $display("FAIL timeout_res: res=%0d err=%b want 0 1", r, e); end
        m_hang = 1'b0;
        run_op(1, 8'd6, 8'd7, 20, g, d, lat, r, e);
        checks++; if (r !== 16'd42 || e !== 1'b0 || lat !== 10) begin errors++; $display("FAIL after_timeout: res=%0d err=%b lat=%0d want 42 0 10", r, e, lat); end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] g, d;
        logic [2*WIDTH-1:0] r;
        logic e, ms;
        logic [WIDTH-1:0] ma, mb;
        int g_at, d_at, lat;
        int pulses = 0;
        set_ops(1, 8'd9, 8'd9);
        req = 4'b0010;
        wait_gnt(20, g, g_at, ms, ma, mb);
        req = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || gnt !== '0 || done !== '0 || mul_start !== 1'b0) begin errors++; $display("FAIL midrst_ctl: busy=%b gnt=%b done=%b start=%b want 0", busy, gnt, done, mul_start); end
        checks++; if (res !== '0 || res_err !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin errors++; $display("FAIL midrst_data: res=%0d err=%b a=%0d b=%0d want 0", res, res_err, mul_a, mul_b); end
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done != '0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", pulses); end
        set_ops(1, 8'd4, 8'd4);
        set_ops(2, 8'd3, 8'd5);
        req = 4'b0110;
        wait_gnt(20, g, g_at, ms, ma, mb);
        req = '0;
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL midrst_ptr: got %b want 0010", g); end
        wait_done(20, d, d_at, r, e);
        checks++; if (r !== 16'd16) begin errors++; $display("FAIL midrst_first: got %0d want 16", r); end
        run_op(2, 8'd3, 8'd5, 20, g, d, lat, r, e);
        checks++; if (d !== 4'b0100 || r !== 16'd15 || lat !== 10) begin errors++; $display("FAIL midrst_req2: done=%b res=%0d lat=%0d want 0100 15 10", d, r, lat); end
    endtask

    task automatic test_exclusive();
        bit idle = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (!$onehot0(gnt) || !$onehot0(done) || ((gnt != '0) && (done != '0)) || (mul_start !== (gnt != '0))) begin
                errors++; $display("FAIL exclusive_c%0d: gnt=%b done=%b start=%b", k, gnt, done, mul_start);
            end
        end
        req = '0;
        for (int k = 0; k < 30 && !idle; k++) begin
            @(negedge clk);
            if (busy == 1'b0) idle = 1'b1;
        end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL exclusive_drain: busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_max_operands();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter WIDTH, default 8, is the operand width; results are 2*WIDTH bits.
REQ-002 Parameter NREQ, default 4, is the number of requesters.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; all state changes on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req  input  NREQ  per-requester operation request, level.
REQ-007 a_in  input  NREQ*WIDTH  flattened multiplicands; slice i belongs to requester i.
REQ-008 b_in  input  NREQ*WIDTH  flattened multipliers; slice i belongs to requester i.
REQ-009 gnt  output  NREQ  one-hot, one-cycle pulse marking operand capture.
REQ-010 done  output  NREQ  one-hot, one-cycle pulse marking result valid.
REQ-011 res  output  2*WIDTH  result, valid only while any done bit is high.
REQ-012 res_err  output  1  timeout flag, valid with done.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 mul_start  output  1  start strobe to the shared iterative multiplier.
REQ-015 mul_a, mul_b  output  WIDTH each  operands to the multiplier.
REQ-016 mul_out  input  2*WIDTH  multiplier product.
REQ-017 mul_ready  input  1  multiplier completion level; it is low from the first edge after a start until completion, then it stays high.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-019 IDLE with req nonzero: at the edge, latch the round-robin winner and its a_in/b_in slices, then go to ISSUE; otherwise stay in IDLE.
REQ-020 ISSUE lasts exactly one cycle: gnt[winner]=1, mul_start=1, and mul_a/mul_b carry the latched operands; next state is WAIT.
REQ-021 WAIT: the first edge with mul_ready=1 captures mul_out into res, and the next state is DONE.
REQ-022 mul_ready SHALL be ignored outside WAIT, so a stale high level from a previous operation is never consumed.
REQ-023 DONE lasts exactly one cycle: done[winner]=1, res valid, res_err=0; next state is IDLE.
REQ-024 Latency is fixed: done is asserted WIDTH+2 cycles after the gnt cycle, and the minimum issue-to-issue spacing is WIDTH+4 cycles.
REQ-025 Timeout: the WAIT cycle counter saturates; if WIDTH+4 edges pass without mul_ready, go to DONE with res=0 and res_err=1.
REQ-026 Arbitration is round-robin: the priority pointer resets to 0, and after a grant to i it becomes (i+1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-027 Operands SHALL be sampled only at the IDLE decision edge; changes to req, a_in or b_in during ISSUE, WAIT or DONE SHALL NOT affect the operation in flight.
REQ-028 A requester holding req high is re-granted in rotation order; a requester that wants one operation drops req after its gnt.
REQ-029 Products are unsigned and full width, with no truncation.
REQ-030 mul_start, gnt and done SHALL never be high in the same cycle, and each SHALL be at most one-hot.

Reset
REQ-031 While rst_n=0 at an edge, the block SHALL set: state IDLE, pointer 0, and gnt, done, res, res_err, busy, mul_start, mul_a and mul_b all 0.
REQ-032 Reset in the middle of an operation discards the operation silently (no done pulse); the next ISSUE restarts the multiplier.

Structure
REQ-033 A shared package mult_sched_pkg SHALL hold the FSM state enum, the default WIDTH/NREQ constants and the timeout margin constant (4).
REQ-034 The round-robin winner and pointer-update logic SHALL be a sub-module rr_arbiter (inputs req and pointer; output one-hot grant); the FSM stays in mult_scheduler.

Verification
REQ-035 Single requester: req[0] with a=13, b=11 -> gnt[0] for one cycle, then done[0] 10 cycles later with res=143 and res_err=0.
REQ-036 Simultaneous requests: req=4'b1111 held -> grants in the order 0,1,2,3,0, spaced 12 cycles apart, each with the correct product.
REQ-037 Maximum operands: a=255, b=255 -> res=65025; a=0, b=200 -> res=0.
REQ-038 Wrap and fairness: pointer at 3, req=4'b1001 -> requester 3 is granted, then requester 0; requester 3 is never granted twice in a row while req[0] is high.
REQ-039 Timeout: the multiplier model holds mul_ready low -> after 12 WAIT edges, done[winner]=1 with res_err=1 and res=0; the next request proceeds normally.
REQ-040 Reset mid-WAIT: rst_n low for one edge -> no done pulse, all outputs 0, pointer 0; a subsequent req[2] with a=3, b=5 -> res=15.
